// File: rtl/servo_pkg.sv
// Shared constants for the servo display path.
// Also used by the seven-segment debug controller for its left/neutral/right thresholds.
package servo_pkg;

  localparam int SERVO_MIN_US    = 1000;
  localparam int SERVO_CENTER_US = 1500;
  localparam int SERVO_MAX_US    = 1999;

  typedef logic [10:0] width_us_t;

endpackage

// File: rtl/servo_pos_map.sv
// Maps a strobed 10-bit joystick position to a pulse width in microseconds, with a deadband around center.
// Holds the target-width register that the frame logic picks up at each frame boundary.
module servo_pos_map
  import servo_pkg::*;
#(
  parameter int DEADBAND_US = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] i_pos,
  input  logic       i_pos_valid,
  output logic [10:0] o_tgt
);

  localparam width_us_t MIN_W    = width_us_t'(SERVO_MIN_US);
  localparam width_us_t CENTER_W = width_us_t'(SERVO_CENTER_US);
  localparam width_us_t BAND_LO  = width_us_t'(SERVO_CENTER_US - DEADBAND_US);
  localparam width_us_t BAND_HI  = width_us_t'(SERVO_CENTER_US + DEADBAND_US);

  logic [9:0] w_scaled;
  width_us_t  w_raw;
  logic       w_in_band;
  width_us_t  r_tgt;

  // pos * 125 / 128 spreads 0..1023 over 0..999 us without a divider.
  assign w_scaled  = 10'((17'(i_pos) * 17'd125) >> 7);
  assign w_raw     = MIN_W + {1'b0, w_scaled};
  assign w_in_band = (w_raw > BAND_LO) && (w_raw < BAND_HI);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tgt <= CENTER_W;
    end else if (i_pos_valid) begin
      r_tgt <= w_in_band ? CENTER_W : w_raw;
    end
  end

  assign o_tgt = r_tgt;

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz RC-servo pulse generator: microsecond prescaler, frame counter and registered PWM comparator.
// Define SERVO_SLEW_LIMIT_EN to limit the width change per frame to SLEW_US.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_PER_US  = 100,
  parameter int FRAME_US    = 20000,
  parameter int DEADBAND_US = 20,
  parameter int SLEW_US     = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  POS,
  input  logic        POS_VALID,
  output logic        PWM,
  output logic [10:0] WIDTH_US,
  output logic        FRAME_START
);

  localparam int US_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int FR_W = ($clog2(FRAME_US) > 11) ? $clog2(FRAME_US) : 11;
  localparam logic [US_W-1:0] US_LAST = US_W'(CLK_PER_US - 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAME_US - 1);
  localparam int FULL_RANGE = SERVO_MAX_US - SERVO_MIN_US + 1;
`ifdef SERVO_SLEW_LIMIT_EN
  localparam width_us_t STEP_LIM = width_us_t'(SLEW_US);
`else
  // The cap never falls below the full range, so act always lands on tgt in one boundary.
  localparam width_us_t STEP_LIM = width_us_t'((SLEW_US > FULL_RANGE) ? SLEW_US : FULL_RANGE);
`endif

  width_us_t       w_tgt;
  width_us_t       w_diff;
  width_us_t       w_next_act;
  logic            w_up;
  logic            w_us_tick;
  logic            w_wrap;

  logic [US_W-1:0] r_us_cnt;
  logic [FR_W-1:0] r_fr_cnt;
  width_us_t       r_act;
  logic            r_pwm;
  logic            r_frame_start;

  servo_pos_map #(
    .DEADBAND_US (DEADBAND_US)
  ) u_pos_map (
    .CLK         (CLK),
    .RST         (RST),
    .i_pos       (POS),
    .i_pos_valid (POS_VALID),
    .o_tgt       (w_tgt)
  );

  assign w_us_tick = (r_us_cnt == US_LAST);
  assign w_wrap    = w_us_tick && (r_fr_cnt == FR_LAST);

  assign w_up   = (w_tgt > r_act);
  assign w_diff = w_up ? (w_tgt - r_act) : (r_act - w_tgt);

  always_comb begin
    w_next_act = w_tgt;
    if (w_diff > STEP_LIM) begin
      w_next_act = w_up ? (r_act + STEP_LIM) : (r_act - STEP_LIM);
    end
  end

  // act only changes on the wrap cycle, so a running pulse is never cut short or stretched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_us_cnt      <= '0;
      r_fr_cnt      <= '0;
      r_act         <= width_us_t'(SERVO_CENTER_US);
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_us_cnt <= w_us_tick ? '0 : r_us_cnt + US_W'(1);
      if (w_us_tick) begin
        r_fr_cnt <= (r_fr_cnt == FR_LAST) ? '0 : r_fr_cnt + FR_W'(1);
      end
      if (w_wrap) begin
        r_act <= w_next_act;
      end
      r_frame_start <= w_wrap;
      r_pwm         <= (r_fr_cnt < FR_W'(r_act));
    end
  end

  assign PWM         = r_pwm;
  assign WIDTH_US    = r_act;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with a shortened frame (2 clk/us, 2000 us frame) to keep runtime small.
// A cycle-level reference model derived from elapsed time checks every cycle; tables and sequences add targeted checks.
module tb_servo_pwm_gen;

  localparam int C    = 2;
  localparam int F    = 2000;
  localparam int FC   = C * F;
  localparam int DB   = 20;
  localparam int SLEW = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  POS = '0;
  logic        POS_VALID = 1'b0;
  logic        PWM;
  logic [10:0] WIDTH_US;
  logic        FRAME_START;

  int checks   = 0;
  int failures = 0;
  int model_prints = 0;

  always #5 CLK = ~CLK;

  servo_pwm_gen #(
    .CLK_PER_US  (C),
    .FRAME_US    (F),
    .DEADBAND_US (DB),
    .SLEW_US     (SLEW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .POS         (POS),
    .POS_VALID   (POS_VALID),
    .PWM         (PWM),
    .WIDTH_US    (WIDTH_US),
    .FRAME_START (FRAME_START)
  );

  // ---------------- reference model ----------------
  int   m_n;
  int   m_tgt;
  int   m_act;
  logic m_pwm;
  logic m_fs;
  bit   m_ok = 1'b0;

  function automatic int map_pos(input int p);
    int raw;
    raw = 1000 + (p * 125) / 128;
    if ((raw - 1500 < DB) && (1500 - raw < DB)) return 1500;
    return raw;
  endfunction

  function automatic int next_width(input int act, input int tgt);
`ifdef SERVO_SLEW_LIMIT_EN
    if (tgt > act + SLEW) return act + SLEW;
    if (tgt < act - SLEW) return act - SLEW;
`endif
    return tgt;
  endfunction

  // Elapsed clocks since reset release determine frame position; the pulse is high for the first act us.
  always @(posedge CLK) begin
    if (RST) begin
      m_n   = 0;
      m_tgt = 1500;
      m_act = 1500;
      m_pwm = 1'b0;
      m_fs  = 1'b0;
    end else begin
      m_n++;
      m_pwm = (((m_n - 1) % FC) / C) < m_act;
      m_fs  = ((m_n % FC) == 0);
      if (m_fs) m_act = next_width(m_act, m_tgt);
      if (POS_VALID) m_tgt = map_pos(int'(POS));
    end
    m_ok = 1'b1;
  end

  always @(negedge CLK) begin
    if (m_ok) begin
      checks++;
      if (PWM !== m_pwm || FRAME_START !== m_fs || WIDTH_US !== 11'(m_act)) begin
        failures++;
        if (model_prints < 10)
          $display("FAIL model n=%0d pwm=%b exp=%b fs=%b exp=%b width=%0d exp=%0d",
                   m_n, PWM, m_pwm, FRAME_START, m_fs, WIDTH_US, m_act);
        model_prints++;
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Runs until the next FRAME_START; counts PWM-high cycles and cycles elapsed.
  task automatic measure_frame(output int hi, output int len);
    bit found;
    hi = 0;
    len = 0;
    found = 1'b0;
    for (int k = 1; k <= FC + 10 && !found; k++) begin
      @(negedge CLK);
      POS_VALID = 1'b0;
      len = k;
      if (PWM) hi++;
      if (FRAME_START) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout got=%0d expected=%0d", len, FC);
    end
  endtask

  typedef struct {
    int pos;
    int exp_w;
  } vec_t;

  vec_t tbl[9];
  int   n_vec;
  int   hi, len, prev, e_w1, e_w2;
  bit   found;

  initial begin
`ifdef SERVO_SLEW_LIMIT_EN
    tbl[0] = '{1023, 1510};
    tbl[1] = '{1023, 1520};
    tbl[2] = '{1023, 1530};
    tbl[3] = '{0,    1520};
    tbl[4] = '{533,  1520};
    n_vec  = 5;
    e_w1   = 1510;
    e_w2   = 1520;
`else
    tbl[0] = '{0,    1000};
    tbl[1] = '{1023, 1999};
    tbl[2] = '{600,  1585};
    tbl[3] = '{520,  1500};
    tbl[4] = '{506,  1500};
    tbl[5] = '{540,  1527};
    tbl[6] = '{492,  1480};
    tbl[7] = '{493,  1500};
    tbl[8] = '{533,  1520};
    n_vec  = 9;
    e_w1   = 1000;
    e_w2   = 1999;
`endif

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_pwm", int'(PWM), 0);
    check("reset_fs", int'(FRAME_START), 0);
    check("reset_width", int'(WIDTH_US), 1500);
    RST = 1'b0;

    // Idle frames at center width
    for (int f = 0; f < 2; f++) begin
      measure_frame(hi, len);
      check("idle_high_time", hi, 1500 * C);
      check("idle_frame_len", len, FC);
      check("idle_width", int'(WIDTH_US), 1500);
    end

    // Table: strobe early in each frame, new width appears at the next boundary
    prev = 1500;
    for (int i = 0; i < n_vec; i++) begin
      POS = 10'(tbl[i].pos);
      POS_VALID = 1'b1;
      measure_frame(hi, len);
      check("vec_width", int'(WIDTH_US), tbl[i].exp_w);
      check("vec_high_time", hi, prev * C);
      check("vec_frame_len", len, FC);
      prev = tbl[i].exp_w;
    end

    // Two strobes in one frame plus one on the wrap cycle
    hi = 0;
    found = 1'b0;
    for (int k = 1; k <= FC + 10 && !found; k++) begin
      @(negedge CLK);
      POS_VALID = 1'b0;
      if (PWM) hi++;
      if (FRAME_START) begin
        found = 1'b1;
        check("multi_len", k, FC);
      end else begin
        if (k == 100)  begin POS = 10'd512;  POS_VALID = 1'b1; end
        if (k == 2000) begin POS = 10'd0;    POS_VALID = 1'b1; end
        if (k == FC - 1) begin POS = 10'd1023; POS_VALID = 1'b1; end
        if (k == 500) check("midframe_width", int'(WIDTH_US), 1520);
      end
    end
    check("multi_found", int'(found), 1);
    check("multi_width1", int'(WIDTH_US), e_w1);
    check("multi_high1", hi, 1520 * C);
    measure_frame(hi, len);
    check("wrap_strobe_width2", int'(WIDTH_US), e_w2);
    check("multi_high2", hi, e_w1 * C);

    // Reset asserted in the middle of a pulse
    repeat (1000) @(negedge CLK);
    check("pre_reset_pwm", int'(PWM), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midreset_pwm", int'(PWM), 0);
    check("midreset_width", int'(WIDTH_US), 1500);
    check("midreset_fs", int'(FRAME_START), 0);
    @(negedge CLK);
    RST = 1'b0;
    measure_frame(hi, len);
    check("post_reset_high", hi, 1500 * C);
    check("post_reset_len", len, FC);

    // Random strobes, including one on each wrap cycle; the model checks every cycle
    for (int k = 1; k <= 3 * FC; k++) begin
      @(negedge CLK);
      POS_VALID = 1'b0;
      if ((k % FC) == FC - 1 || $urandom_range(0, 299) == 0) begin
        POS = 10'($urandom_range(0, 1023));
        POS_VALID = 1'b1;
      end
    end
    @(negedge CLK);
    POS_VALID = 1'b0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
